// File: rtl/attn_pkg.sv
// attn_pkg: shared width default, saturation limits and opcodes for the attention datapath
package attn_pkg;
    localparam int DEF_DATA_WIDTH = 16;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    function automatic logic [63:0] maxpos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction
    function automatic logic [63:0] minneg(input int w);
        return ~maxpos(w);
    endfunction
    localparam logic [DEF_DATA_WIDTH-1:0] MAXPOS = DEF_DATA_WIDTH'(maxpos(DEF_DATA_WIDTH));
    localparam logic [DEF_DATA_WIDTH-1:0] MINNEG = DEF_DATA_WIDTH'(minneg(DEF_DATA_WIDTH));
endpackage

// File: rtl/fixed_point_sub_pipe_if.sv
// fixed_point_sub_pipe_if: operand/result handshake and counter bundle for the add/sub pipe
interface fixed_point_sub_pipe_if #(
    parameter int DATA_WIDTH = attn_pkg::DEF_DATA_WIDTH,
    parameter int NUM_LANES  = 4,
    parameter int CNT_WIDTH  = 16
);
    logic                            op, b_load, in_valid, in_ready, out_valid, out_ready, sat_clr;
    logic [DATA_WIDTH-1:0]           b_in;
    logic [NUM_LANES*DATA_WIDTH-1:0] a_in, out_data;
    logic [NUM_LANES-1:0]            out_sat;
    logic [CNT_WIDTH-1:0]            sat_count;
    modport master (
        output op, b_load, b_in, in_valid, a_in, out_ready, sat_clr,
        input  in_ready, out_valid, out_data, out_sat, sat_count
    );
    modport slave (
        input  op, b_load, b_in, in_valid, a_in, out_ready, sat_clr,
        output in_ready, out_valid, out_data, out_sat, sat_count
    );
endinterface

// File: rtl/sat_addsub_lane.sv
// sat_addsub_lane: one lane; widened signed add/sub of (a, b, op) and saturation of a registered sum
module sat_addsub_lane
    import attn_pkg::*;
#(
    parameter int W = DEF_DATA_WIDTH
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    input  logic [W:0]   r,
    output logic [W:0]   sum,
    output logic [W-1:0] result,
    output logic         sat
);
    localparam logic [W-1:0] MAXP = W'(maxpos(W));
    localparam logic [W-1:0] MINN = W'(minneg(W));
    logic [W:0] bx;
    // Negation happens at W+1 bits so the most negative B flips to a representable positive value
    always_comb begin
        bx     = {b[W-1], b};
        sum    = {a[W-1], a} + (op == OP_SUB ? -bx : bx);
        sat    = r[W] ^ r[W-1];
        result = sat ? (r[W] ? MINN : MAXP) : r[W-1:0];
    end
endmodule

// File: rtl/fixed_point_sub_pipe.sv
// fixed_point_sub_pipe: N-lane two-stage saturating add/sub against a held broadcast operand
module fixed_point_sub_pipe
    import attn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_LANES  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input logic                clk,
    input logic                rst,
    fixed_point_sub_pipe_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int PW = $clog2(NUM_LANES + 1);
    logic [W-1:0]                  b_q, b_eff;
    logic                          s1_v, adv, accept;
    logic [NUM_LANES-1:0][W:0]     s1_r, sum;
    logic [NUM_LANES-1:0][W-1:0]   res;
    logic [NUM_LANES-1:0]          sat;
    logic [PW-1:0]                 pop;
    logic [CNT_WIDTH:0]            cnt_sum;
    always_comb begin
        adv          = !bus.out_valid || bus.out_ready;
        bus.in_ready = !s1_v || adv;
        accept       = bus.in_valid && bus.in_ready;
        b_eff        = bus.b_load ? bus.b_in : b_q;
        pop          = '0;
        for (int i = 0; i < NUM_LANES; i++) pop = pop + PW'(bus.out_sat[i]);
        cnt_sum      = {1'b0, bus.sat_count} + (CNT_WIDTH + 1)'(pop);
    end
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        sat_addsub_lane #(.W(W)) u_lane (
            .a(bus.a_in[i*W +: W]), .b(b_eff), .op(bus.op), .r(s1_r[i]),
            .sum(sum[i]), .result(res[i]), .sat(sat[i])
        );
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            b_q           <= '0;
            s1_v          <= 1'b0;
            s1_r          <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sat   <= '0;
            bus.sat_count <= '0;
        end else begin
            if (bus.b_load) b_q <= bus.b_in;
            if (bus.in_ready) begin
                s1_v <= accept;
                if (accept) s1_r <= sum;
            end
            if (adv) begin
                bus.out_valid <= s1_v;
                if (s1_v) begin
                    bus.out_data <= res;
                    bus.out_sat  <= sat;
                end
            end
            if (bus.sat_clr) bus.sat_count <= '0;
            else if (bus.out_valid && bus.out_ready)
                bus.sat_count <= cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
        end
    end
endmodule

// File: tb/tb_fixed_point_sub_pipe.sv
// tb_fixed_point_sub_pipe: scoreboard bench for the saturating add/sub pipe
module tb_fixed_point_sub_pipe;
    import attn_pkg::*;
    localparam int DW = 16, NL = 4, CW = 16;
    typedef struct packed {
        logic [NL*DW-1:0] data;
        logic [NL-1:0]    sat;
        int               cyc;
        logic             lat;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    int passed = 0, checks = 0, cyc = 0, or_mode = 0;
    logic [DW-1:0] b_model = '0;
    logic [CW-1:0] m_cnt = '0;
    logic lat_on = 1'b0, stalled = 1'b0;
    logic [NL*DW-1:0] prev_data = '0;
    logic [NL-1:0] prev_sat = '0;
    fixed_point_sub_pipe_if #(.DATA_WIDTH(DW), .NUM_LANES(NL), .CNT_WIDTH(CW)) bus ();
    fixed_point_sub_pipe #(.DATA_WIDTH(DW), .NUM_LANES(NL), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #2;
        bus.out_ready = (or_mode == 0) ? 1'b1 : (or_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    function automatic exp_t model(input logic [NL*DW-1:0] a, input logic o, input logic [DW-1:0] b);
        exp_t e;
        int av, bv, r;
        logic [31:0] rr;
        e = '0;
        bv = int'($signed(b));
        for (int i = 0; i < NL; i++) begin
            av = int'($signed(a[i*DW +: DW]));
            r = o ? av - bv : av + bv;
            e.sat[i] = (r > 32767) || (r < -32768);
            rr = r;
            e.data[i*DW +: DW] = (r > 32767) ? MAXPOS : (r < -32768) ? MINNEG : rr[DW-1:0];
        end
        e.cyc = cyc;
        e.lat = lat_on;
        return e;
    endfunction
    task automatic send(input logic [NL*DW-1:0] a, input logic o, input logic bl, input logic [DW-1:0] bi);
        int n = 0;
        bus.a_in = a; bus.op = o; bus.b_load = bl; bus.b_in = bi; bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", bus.in_ready, 1);
        else q.push_back(model(a, o, bl ? bi : b_model));
        @(posedge clk);
        #1;
        if (bl) b_model = bi;
        bus.in_valid = 1'b0;
        bus.b_load = 1'b0;
    endtask
    task automatic loadb(input logic [DW-1:0] v);
        bus.b_load = 1'b1; bus.b_in = v;
        @(posedge clk);
        #1;
        bus.b_load = 1'b0;
        b_model = v;
    endtask
    task automatic clr();
        bus.sat_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.sat_clr = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin : mon
        exp_t e;
        int nxt;
        if (rst) begin
            q.delete();
            m_cnt = '0;
            stalled = 1'b0;
        end else begin
            chk("sat_count_track", bus.sat_count, m_cnt);
            if (stalled) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, prev_data);
                chk("hold_sat", bus.out_sat, prev_sat);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("beat_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("out_data", bus.out_data, e.data);
                    chk("out_sat", bus.out_sat, e.sat);
                    if (e.lat) chk("latency", cyc - e.cyc, 2);
                    nxt = int'(m_cnt) + $countones(e.sat);
                    m_cnt = (nxt > 65535) ? 16'hFFFF : CW'(nxt);
                end
            end
            if (bus.sat_clr) m_cnt = '0;
            stalled = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            prev_sat = bus.out_sat;
        end
    end
    initial begin
        bus.op = 1'b0; bus.b_load = 1'b0; bus.b_in = '0; bus.in_valid = 1'b0;
        bus.a_in = '0; bus.sat_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_sat", bus.out_sat, 0);
        chk("rst_sat_count", bus.sat_count, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        // subtract with latency check
        loadb(16'h0100);
        lat_on = 1'b1;
        send({16'hFF00, 16'h0000, 16'h0100, 16'h0300}, 1'b1, 1'b0, '0);
        lat_on = 1'b0;
        drain();
        // saturation corners, one saturating lane per beat
        clr();
        send({16'h0000, 16'h0000, 16'h0000, 16'h7FF0}, 1'b0, 1'b1, 16'h0020);
        send({16'h0000, 16'h0000, 16'h0000, 16'h8000}, 1'b1, 1'b1, 16'h0001);
        send({16'hC000, 16'h8000, 16'hFFFF, 16'h0000}, 1'b1, 1'b1, 16'h8000);
        drain();
        chk("sat_count_3", bus.sat_count, 3);
        // backpressure: fill both stages, then random ready
        or_mode = 1;
        send({$urandom(), $urandom()}, 1'($urandom_range(0, 1)), 1'b0, '0);
        send({$urandom(), $urandom()}, 1'($urandom_range(0, 1)), 1'b0, '0);
        chk("full_in_ready", bus.in_ready, 0);
        or_mode = 2;
        for (int i = 0; i < 6; i++) send({$urandom(), $urandom()}, 1'($urandom_range(0, 1)), 1'b0, '0);
        drain();
        or_mode = 0;
        // b_load bypass then held B
        send({16'h0070, 16'h0060, 16'h0050, 16'h0050}, 1'b1, 1'b1, 16'h0010);
        send({16'h0100, 16'h0100, 16'h0100, 16'h0100}, 1'b1, 1'b0, '0);
        drain();
        // reset with two beats in flight
        or_mode = 1;
        send({16'h1111, 16'h2222, 16'h3333, 16'h4444}, 1'b0, 1'b0, '0);
        send({16'h5555, 16'h6666, 16'h7777, 16'h0001}, 1'b1, 1'b0, '0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        b_model = '0;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_sat_count", bus.sat_count, 0);
        or_mode = 0;
        send({16'h0123, 16'h8000, 16'h7FFF, 16'hFFFF}, 1'b1, 1'b0, '0);
        drain();
        // counter stickiness
        clr();
        for (int i = 0; i < 16383; i++) send({4{16'h7FFF}}, 1'b0, i == 0, 16'h7FFF);
        drain();
        chk("cnt_fffc", bus.sat_count, 16'hFFFC);
        send({4{16'h7FFF}}, 1'b0, 1'b0, '0);
        drain();
        chk("cnt_ffff", bus.sat_count, 16'hFFFF);
        send({4{16'h7FFF}}, 1'b0, 1'b0, '0);
        drain();
        chk("cnt_sticky", bus.sat_count, 16'hFFFF);
        clr();
        chk("cnt_clr", bus.sat_count, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
